// File: rtl/alu_pkg.sv
// Shared constants and the issue-register bundle for the ALU issue stage.
package alu_pkg;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int OPW  = 3;
    localparam int FLW  = 5;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    localparam int FLG_LT = 0;
    localparam int FLG_GT = 1;
    localparam int FLG_EQ = 2;
    localparam int FLG_ZB = 3;
    localparam int FLG_ZA = 4;

    typedef struct packed {
        logic [OPW-1:0] opcode;
        logic           mode;
        logic [AW-1:0]  rd;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } iss_t;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two async read ports, one write port, R0 reads zero.
module alu_regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] rf [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            rf[wa] <= wd;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : rf[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : rf[rb_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue stage: register file, busy scoreboard, registered ALU operands.
// Define ALU_ISSUE_BYPASS_EN to forward same-cycle writeback data to sources.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_opcode,
    input  logic           in_mode,
    input  logic [AW-1:0]  in_rd,
    input  logic [AW-1:0]  in_ra,
    input  logic [AW-1:0]  in_rb,
    input  logic           in_imm_sel,
    input  logic [DW-1:0]  in_imm,
    output logic           iss_valid,
    input  logic           iss_ready,
    output logic [DW-1:0]  a,
    output logic [DW-1:0]  b,
    output logic [OPW-1:0] opcode,
    output logic           mode,
    output logic [AW-1:0]  iss_rd,
    input  logic           wb_en,
    input  logic [AW-1:0]  wb_rd,
    input  logic [DW-1:0]  wb_data,
    input  logic [FLW-1:0] wb_flags,
    output logic [FLW-1:0] status
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            iss_valid_q;
    iss_t            iss_q;
    iss_t            iss_d;
    logic [FLW-1:0]  status_q;
    logic [DW-1:0]   rf_a;
    logic [DW-1:0]   rf_b;
    logic            fwd_a;
    logic            fwd_b;
    logic            haz_a;
    logic            haz_b;
    logic            haz_d;
    logic            hazard;
    logic            accept;

    alu_regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (in_ra),
        .ra_data (rf_a),
        .rb_addr (in_rb),
        .rb_data (rf_b),
        .we      (wb_en),
        .wa      (wb_rd),
        .wd      (wb_data)
    );

`ifdef ALU_ISSUE_BYPASS_EN
    // R0 is excluded: a writeback to R0 must never leak into a read.
    assign fwd_a = wb_en && (wb_rd == in_ra) && (in_ra != '0);
    assign fwd_b = wb_en && (wb_rd == in_rb) && (in_rb != '0);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_comb begin
        haz_a  = (in_ra != '0) && busy[in_ra] && !fwd_a;
        haz_b  = !in_imm_sel && (in_rb != '0) && busy[in_rb] && !fwd_b;
        haz_d  = (in_rd != '0) && busy[in_rd];
        hazard = haz_a || haz_b || haz_d;
    end

    assign in_ready = (!iss_valid_q || iss_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        iss_d        = iss_q;
        iss_d.opcode = in_opcode;
        iss_d.mode   = in_mode;
        iss_d.rd     = in_rd;
        iss_d.a      = fwd_a ? wb_data : rf_a;
        if (in_imm_sel) begin
            iss_d.b = in_imm;
        end else begin
            iss_d.b = fwd_b ? wb_data : rf_b;
        end
    end

    // Clear first so a same-edge set on the same bit wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_en && (wb_rd != '0)) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (accept && (in_rd != '0)) begin
            busy_nxt[in_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            status_q    <= '0;
        end else begin
            busy <= busy_nxt;
            if (accept) begin
                iss_valid_q <= 1'b1;
                iss_q       <= iss_d;
            end else if (iss_ready) begin
                iss_valid_q <= 1'b0;
            end
            if (wb_en) begin
                status_q <= wb_flags;
            end
        end
    end

    assign iss_valid = iss_valid_q;
    assign a         = iss_q.a;
    assign b         = iss_q.b;
    assign opcode    = iss_q.opcode;
    assign mode      = iss_q.mode;
    assign iss_rd    = iss_q.rd;
    assign status    = status_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: program-order register model,
// emulated downstream ALU driving writebacks, directed and random streams.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [OPW-1:0] in_opcode = '0;
    logic           in_mode = 1'b0;
    logic [AW-1:0]  in_rd = '0;
    logic [AW-1:0]  in_ra = '0;
    logic [AW-1:0]  in_rb = '0;
    logic           in_imm_sel = 1'b0;
    logic [DW-1:0]  in_imm = '0;
    logic           iss_valid;
    logic           iss_ready = 1'b0;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] opcode;
    logic           mode;
    logic [AW-1:0]  iss_rd;
    logic           wb_en = 1'b0;
    logic [AW-1:0]  wb_rd = '0;
    logic [DW-1:0]  wb_data = '0;
    logic [FLW-1:0] wb_flags = '0;
    logic [FLW-1:0] status;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_mode    (in_mode),
        .in_rd      (in_rd),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .mode       (mode),
        .iss_rd     (iss_rd),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_flags   (wb_flags),
        .status     (status)
    );

    always #5 clk = ~clk;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    typedef struct {
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [OPW-1:0] op;
        logic           mode;
        logic [AW-1:0]  rd;
    } exp_t;

    typedef struct {
        int             due;
        logic [AW-1:0]  rd;
        logic [DW-1:0]  data;
        logic [FLW-1:0] flags;
    } wb_t;

    exp_t          exp_q[$];
    wb_t           wbq[$];
    logic [DW-1:0] mreg [NREG];

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    bit auto_wb = 1'b1;
    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;
    int dly_min = 0;
    int dly_max = 0;
    int wb_cyc = -100;
    bit stat_pend = 1'b0;
    logic [FLW-1:0] exp_stat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] x, logic [DW-1:0] y,
                                             logic [OPW-1:0] op, logic md);
        logic [DW-1:0] r;
        case (op)
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = x & y;
            3'd3:    r = x | y;
            3'd4:    r = x ^ y;
            3'd5:    r = x << y[3:0];
            3'd6:    r = x >> y[3:0];
            default: r = y;
        endcase
        return md ? ~r : r;
    endfunction

    function automatic logic [FLW-1:0] flags_of(logic [DW-1:0] x, logic [DW-1:0] y);
        return {x == '0, y == '0, x == y, x > y, x < y};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Downstream ready: random or forced per cycle.
    initial forever begin
        @(posedge clk);
        #2;
        iss_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_force;
    end

    // Monitor: compare every consumed op and hand it to the emulated ALU.
    initial begin
        exp_t e;
        wb_t  w;
        forever begin
            @(negedge clk);
            if (rst_n && iss_valid && iss_ready) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_issue: got rd=%0d a=%0h with no op expected", iss_rd, a);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue{a,b,op,mode,rd}", {a, b, opcode, mode, iss_rd},
                        {e.a, e.b, e.op, e.mode, e.rd});
                end
                if (auto_wb) begin
                    w.due   = cyc + 1 + $urandom_range(dly_max, dly_min);
                    w.rd    = iss_rd;
                    w.data  = alu_fn(a, b, opcode, mode);
                    w.flags = flags_of(a, b);
                    wbq.push_back(w);
                end
            end
        end
    end

    // Writeback driver plus status check one edge after each writeback.
    initial begin
        wb_t w;
        forever begin
            @(posedge clk);
            #1;
            if (stat_pend && rst_n) chk("status", status, exp_stat);
            stat_pend = 1'b0;
            if (rst_n && wbq.size() > 0 && wbq[0].due <= cyc) begin
                w         = wbq.pop_front();
                wb_en     = 1'b1;
                wb_rd     = w.rd;
                wb_data   = w.data;
                wb_flags  = w.flags;
                exp_stat  = w.flags;
                stat_pend = 1'b1;
                wb_cyc    = cyc;
            end else begin
                wb_en = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mreg[i] = '0;
    endtask

    task automatic model_accept();
        exp_t e;
        e.a    = mreg[in_ra];
        e.b    = in_imm_sel ? in_imm : mreg[in_rb];
        e.op   = in_opcode;
        e.mode = in_mode;
        e.rd   = in_rd;
        exp_q.push_back(e);
        if (in_rd != '0) mreg[in_rd] = alu_fn(e.a, e.b, e.op, e.mode);
    endtask

    task automatic manual_wb(input logic [AW-1:0] rd, input logic [DW-1:0] d,
                             input logic [FLW-1:0] f);
        wb_t w;
        w.due   = cyc + 1;
        w.rd    = rd;
        w.data  = d;
        w.flags = f;
        wbq.push_back(w);
        if (rd != '0) mreg[rd] = d;
    endtask

    task automatic present(input logic [2:0] op, input logic md, input logic [2:0] rd,
                           input logic [2:0] ra, input logic [2:0] rb,
                           input logic sel, input logic [DW-1:0] imm);
        in_opcode  = op;
        in_mode    = md;
        in_rd      = rd;
        in_ra      = ra;
        in_rb      = rb;
        in_imm_sel = sel;
        in_imm     = imm;
        in_valid   = 1'b1;
    endtask

    task automatic wait_accept(input int maxw, output int acc);
        acc = -1;
        for (int i = 0; i < maxw; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept();
                acc = cyc;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        vecs++;
        errs++;
        $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", maxw);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && wbq.size() == 0 && !wb_en && !iss_valid) begin
                step(2);
                return;
            end
        end
        vecs++;
        errs++;
        $display("FAIL drain_timeout: got %0d ops pending, required 0", exp_q.size());
    endtask

    initial begin
        int acc;
        int acc2;
        int rel;
        model_reset();
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_opcode_mode_rd", {opcode, mode, iss_rd}, 0);
        chk("rst_status", status, 0);
        chk("rst_in_ready", in_ready, 1);

        // Writeback into R1, then read it back through an issue.
        manual_wb(3'd1, 16'h1234, 5'b00100);
        step(3);
        present(3'd0, MODE_ARITH, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0);
        wait_accept(10, acc);
        chk("issue_latency_valid", iss_valid, 1);
        chk("status_after_wb1", status, 5'b00100);
        idle();

        // RAW dependency on R2.
        dly_min = 2;
        dly_max = 2;
        present(3'd0, MODE_ARITH, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0005);
        wait_accept(10, acc);
        present(3'd1, MODE_ARITH, 3'd5, 3'd2, 3'd0, 1'b0, 16'h00ff);
        wait_accept(20, acc2);
        chk("raw_accept_cycle", acc2, wb_cyc + 1 - BYP);
        idle();

        // Downstream backpressure holds the issue register.
        rdy_force = 1'b0;
        present(3'd2, MODE_LOGIC, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0);
        wait_accept(10, acc);
        present(3'd3, MODE_ARITH, 3'd7, 3'd1, 3'd0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_outputs", {iss_valid, a, b, opcode, mode, iss_rd},
                {1'b1, exp_q[0].a, exp_q[0].b, exp_q[0].op, exp_q[0].mode, exp_q[0].rd});
            step(1);
        end
        rdy_force = 1'b1;
        rel = cyc;
        wait_accept(10, acc);
        chk("hold_release_accept", acc, rel);
        idle();

        // WAW on R3 stalls until the first writer retires.
        dly_min = 4;
        dly_max = 4;
        present(3'd4, MODE_ARITH, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
        wait_accept(10, acc);
        present(3'd7, MODE_ARITH, 3'd3, 3'd0, 3'd0, 1'b1, 16'hbeef);
        wait_accept(20, acc2);
        chk("waw_accept_cycle", acc2, wb_cyc + 1);
        present(3'd0, MODE_ARITH, 3'd0, 3'd3, 3'd0, 1'b1, 16'h0001);
        @(negedge clk);
        chk("busy3_after_waw", in_ready, 0);
        step(1);
        wait_accept(30, acc);
        idle();

        // Writeback to R0: status moves, R0 stays zero.
        dly_min = 0;
        dly_max = 0;
        manual_wb(3'd0, 16'hffff, 5'b10101);
        step(3);
        chk("status_wb_r0", status, 5'b10101);
        present(3'd4, MODE_ARITH, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0);
        wait_accept(10, acc);
        idle();

        // Reset while an op is held and R4 is busy.
        rdy_force = 1'b0;
        present(3'd1, MODE_LOGIC, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0);
        wait_accept(10, acc);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        wbq.delete();
        stat_pend = 1'b0;
        model_reset();
        #1;
        chk("midrst_iss_valid", iss_valid, 0);
        chk("midrst_outputs", {a, b, opcode, mode, iss_rd}, 0);
        chk("midrst_status", status, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        step(1);
        present(3'd0, MODE_ARITH, 3'd5, 3'd4, 3'd4, 1'b0, 16'h0);
        rel = cyc;
        wait_accept(5, acc);
        chk("ready_after_reset", acc, rel);
        idle();

        // Random stream with random backpressure and writeback delay.
        rdy_rand = 1'b1;
        dly_min = 0;
        dly_max = 3;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) step(1);
            present(3'($urandom_range(7)), 1'($urandom_range(1)), 3'($urandom_range(7)),
                    3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                    16'($urandom));
            wait_accept(60, acc);
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        idle();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
